// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with thresholds, optional first-word-fall-through,
// non-power-of-2 depth, fill level, read-valid strobe and synchronous flush.
module param_sync_fifo #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = 7,
   parameter int AE_THRESH = 1,
   parameter int FWFT      = 0,
   localparam int LW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             rd_en,
   output logic [WIDTH-1:0] data_out,
   output logic             rd_valid,
   output logic             wr_ack,
   output logic             overflow,
   output logic             underflow,
   output logic             full,
   output logic             empty,
   output logic             almostfull,
   output logic             almostempty,
   output logic [LW-1:0]    level
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
   localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0] level_reg;
   logic          wr_ack_reg, overflow_reg, underflow_reg;
   logic          rd_acc, wr_acc;

   assign full        = (level_reg == LVL_FULL);
   assign empty       = (level_reg == '0);
   assign almostfull  = (level_reg >= LVL_AF);
   assign almostempty = (level_reg <= LVL_AE);
   assign level       = level_reg;
   assign wr_ack      = wr_ack_reg;
   assign overflow    = overflow_reg;
   assign underflow   = underflow_reg;

   // A read frees a slot in the same edge, so a full FIFO can still take a write.
   always_comb begin
      rd_acc = rd_en && !empty;
      wr_acc = wr_en && (!full || rd_acc);
   end

   always_ff @(posedge clk) begin
      if (wr_acc && !flush) begin
         mem[wr_ptr_reg] <= data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         wr_ack_reg    <= 1'b0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else if (flush) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         level_reg     <= '0;
         wr_ack_reg    <= 1'b0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
         end
         if (rd_acc) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
         end
         case ({wr_acc, rd_acc})
            2'b10:   level_reg <= level_reg + LW'(1);
            2'b01:   level_reg <= level_reg - LW'(1);
            default: level_reg <= level_reg;
         endcase
         wr_ack_reg    <= wr_acc;
         overflow_reg  <= wr_en && !wr_acc;
         underflow_reg <= rd_en && !rd_acc;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head entry shown directly; masked while empty so reset presents zero.
         assign data_out = empty ? '0 : mem[rd_ptr_reg];
         assign rd_valid = !empty;
      end else begin : g_std
         logic [WIDTH-1:0] data_out_reg;
         logic             rd_valid_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_out_reg <= '0;
               rd_valid_reg <= 1'b0;
            end else if (flush) begin
               rd_valid_reg <= 1'b0;
            end else if (rd_acc) begin
               data_out_reg <= mem[rd_ptr_reg];
               rd_valid_reg <= 1'b1;
            end else begin
               rd_valid_reg <= 1'b0;
            end
         end

         assign data_out = data_out_reg;
         assign rd_valid = rd_valid_reg;
      end
   endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: a DEPTH=8 standard-read instance and a
// DEPTH=5 first-word-fall-through instance.
module tb_param_sync_fifo;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Instance A: DEPTH=8, FWFT=0
   logic        a_flush = 0, a_wr_en = 0, a_rd_en = 0;
   logic [15:0] a_data_in = '0, a_data_out;
   logic        a_rd_valid, a_wr_ack, a_overflow, a_underflow;
   logic        a_full, a_empty, a_af, a_ae;
   logic [3:0]  a_level;

   param_sync_fifo #(.WIDTH(16), .DEPTH(8), .AF_THRESH(7), .AE_THRESH(1), .FWFT(0)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr_en), .data_in(a_data_in),
      .rd_en(a_rd_en), .data_out(a_data_out), .rd_valid(a_rd_valid), .wr_ack(a_wr_ack),
      .overflow(a_overflow), .underflow(a_underflow), .full(a_full), .empty(a_empty),
      .almostfull(a_af), .almostempty(a_ae), .level(a_level)
   );

   // Instance B: DEPTH=5, FWFT=1
   logic        b_flush = 0, b_wr_en = 0, b_rd_en = 0;
   logic [15:0] b_data_in = '0, b_data_out;
   logic        b_rd_valid, b_wr_ack, b_overflow, b_underflow;
   logic        b_full, b_empty, b_af, b_ae;
   logic [2:0]  b_level;

   param_sync_fifo #(.WIDTH(16), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr_en), .data_in(b_data_in),
      .rd_en(b_rd_en), .data_out(b_data_out), .rd_valid(b_rd_valid), .wr_ack(b_wr_ack),
      .overflow(b_overflow), .underflow(b_underflow), .full(b_full), .empty(b_empty),
      .almostfull(b_af), .almostempty(b_ae), .level(b_level)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic [15:0] d);
      a_wr_en = 1; a_data_in = d;
      step();
      a_wr_en = 0;
   endtask

   task automatic test_reset;
      step(); step();
      checks++; if (a_empty !== 1'b1) $display("FAIL reset_empty got=%0b exp=1", a_empty); else passes++;
      checks++; if (a_ae !== 1'b1) $display("FAIL reset_ae got=%0b exp=1", a_ae); else passes++;
      checks++; if (a_level !== 4'd0) $display("FAIL reset_level got=%0d exp=0", a_level); else passes++;
      checks++; if ({a_wr_ack, a_rd_valid, a_overflow, a_underflow, a_full, a_af} !== 6'b0)
         $display("FAIL reset_pulses got=%b exp=000000", {a_wr_ack, a_rd_valid, a_overflow, a_underflow, a_full, a_af}); else passes++;
      checks++; if ({b_empty, b_rd_valid, b_data_out} !== {1'b1, 1'b0, 16'h0})
         $display("FAIL reset_b got empty=%0b rv=%0b d=%h exp 1 0 0000", b_empty, b_rd_valid, b_data_out); else passes++;
      rst_n = 1;
      step();
      for (int i = 1; i <= 5; i++) a_write(16'(i));
      checks++; if (a_level !== 4'd5) $display("FAIL pre_async_level got=%0d exp=5", a_level); else passes++;
      #2 rst_n = 0;
      #1;
      checks++; if (a_level !== 4'd0) $display("FAIL async_reset_level got=%0d exp=0", a_level); else passes++;
      checks++; if (a_empty !== 1'b1) $display("FAIL async_reset_empty got=%0b exp=1", a_empty); else passes++;
      step();
      rst_n = 1;
      step();
      $display("test_reset done");
   endtask

   task automatic test_fill_drain;
      for (int i = 1; i <= 8; i++) begin
         a_write(16'(i));
         checks++; if (a_level !== 4'(i) || a_wr_ack !== 1'b1)
            $display("FAIL fill_level got=%0d ack=%0b exp=%0d ack=1", a_level, a_wr_ack, i); else passes++;
         checks++; if (a_af !== (i >= 7) || a_full !== (i == 8))
            $display("FAIL fill_flags i=%0d got af=%0b full=%0b", i, a_af, a_full); else passes++;
      end
      a_write(16'h0009);
      checks++; if (a_overflow !== 1'b1 || a_wr_ack !== 1'b0 || a_level !== 4'd8)
         $display("FAIL overflow got ovf=%0b ack=%0b lvl=%0d exp 1 0 8", a_overflow, a_wr_ack, a_level); else passes++;
      a_rd_en = 1;
      for (int i = 1; i <= 8; i++) begin
         step();
         checks++; if (a_rd_valid !== 1'b1 || a_data_out !== 16'(i))
            $display("FAIL drain_data got rv=%0b d=%h exp rv=1 d=%h", a_rd_valid, a_data_out, 16'(i)); else passes++;
      end
      a_rd_en = 0;
      step();
      checks++; if (a_rd_valid !== 1'b0 || a_empty !== 1'b1)
         $display("FAIL drain_end got rv=%0b empty=%0b exp 0 1", a_rd_valid, a_empty); else passes++;
      $display("test_fill_drain done");
   endtask

   task automatic test_full_rw;
      logic [15:0] exp_q [9];
      for (int i = 1; i <= 8; i++) a_write(16'(16'h0100 + i));
      a_wr_en = 1; a_rd_en = 1; a_data_in = 16'hABCD;
      step();
      a_wr_en = 0; a_rd_en = 0;
      checks++; if (a_wr_ack !== 1'b1 || a_rd_valid !== 1'b1 || a_level !== 4'd8 || a_data_out !== 16'h0101)
         $display("FAIL full_rw got ack=%0b rv=%0b lvl=%0d d=%h exp 1 1 8 0101", a_wr_ack, a_rd_valid, a_level, a_data_out); else passes++;
      for (int i = 0; i < 7; i++) exp_q[i] = 16'(16'h0102 + i);
      exp_q[7] = 16'hABCD;
      a_rd_en = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++; if (a_data_out !== exp_q[i])
            $display("FAIL full_rw_order idx=%0d got=%h exp=%h", i, a_data_out, exp_q[i]); else passes++;
      end
      a_rd_en = 0;
      step();
      $display("test_full_rw done");
   endtask

   task automatic test_empty_rw;
      a_wr_en = 1; a_rd_en = 1; a_data_in = 16'h1234;
      step();
      a_wr_en = 0; a_rd_en = 0;
      checks++; if (a_wr_ack !== 1'b1 || a_underflow !== 1'b1 || a_level !== 4'd1 || a_rd_valid !== 1'b0)
         $display("FAIL empty_rw got ack=%0b udf=%0b lvl=%0d rv=%0b exp 1 1 1 0", a_wr_ack, a_underflow, a_level, a_rd_valid); else passes++;
      a_rd_en = 1;
      step();
      checks++; if (a_data_out !== 16'h1234 || a_underflow !== 1'b0)
         $display("FAIL empty_rw_read got d=%h udf=%0b exp 1234 0", a_data_out, a_underflow); else passes++;
      step();
      a_rd_en = 0;
      checks++; if (a_underflow !== 1'b1 || a_level !== 4'd0 || a_rd_valid !== 1'b0)
         $display("FAIL underflow got udf=%0b lvl=%0d rv=%0b exp 1 0 0", a_underflow, a_level, a_rd_valid); else passes++;
      step();
      $display("test_empty_rw done");
   endtask

   task automatic test_flush;
      for (int i = 0; i < 4; i++) a_write(16'(16'h0011 + i));
      a_flush = 1; a_wr_en = 1; a_data_in = 16'h0055;
      step();
      a_flush = 0; a_wr_en = 0;
      checks++; if (a_level !== 4'd0 || a_empty !== 1'b1 || a_wr_ack !== 1'b0)
         $display("FAIL flush got lvl=%0d empty=%0b ack=%0b exp 0 1 0", a_level, a_empty, a_wr_ack); else passes++;
      checks++; if (a_data_out !== 16'h1234)
         $display("FAIL flush_hold got=%h exp=1234", a_data_out); else passes++;
      a_write(16'h0077);
      a_rd_en = 1;
      step();
      a_rd_en = 0;
      checks++; if (a_data_out !== 16'h0077 || a_level !== 4'd0)
         $display("FAIL post_flush got d=%h lvl=%0d exp 0077 0", a_data_out, a_level); else passes++;
      $display("test_flush done");
   endtask

   task automatic test_fwft;
      logic [15:0] exp_q [5];
      b_wr_en = 1; b_data_in = 16'h00AA;
      step();
      b_wr_en = 0;
      checks++; if (b_data_out !== 16'h00AA || b_rd_valid !== 1'b1)
         $display("FAIL fwft_first got d=%h rv=%0b exp 00aa 1", b_data_out, b_rd_valid); else passes++;
      b_wr_en = 1;
      for (int i = 1; i <= 4; i++) begin
         b_data_in = 16'(16'h00B0 + i);
         step();
      end
      b_wr_en = 0;
      checks++; if (b_full !== 1'b1 || b_level !== 3'd5 || b_data_out !== 16'h00AA)
         $display("FAIL fwft_full got full=%0b lvl=%0d d=%h exp 1 5 00aa", b_full, b_level, b_data_out); else passes++;
      b_rd_en = 1;
      step(); step();
      b_rd_en = 0;
      b_wr_en = 1;
      b_data_in = 16'h00C1; step();
      b_data_in = 16'h00C2; step();
      b_wr_en = 0;
      exp_q = '{16'h00B2, 16'h00B3, 16'h00B4, 16'h00C1, 16'h00C2};
      for (int i = 0; i < 5; i++) begin
         checks++; if (b_data_out !== exp_q[i] || b_rd_valid !== 1'b1)
            $display("FAIL fwft_order idx=%0d got d=%h rv=%0b exp %h 1", i, b_data_out, b_rd_valid, exp_q[i]); else passes++;
         b_rd_en = 1;
         step();
         b_rd_en = 0;
      end
      checks++; if (b_empty !== 1'b1 || b_rd_valid !== 1'b0)
         $display("FAIL fwft_end got empty=%0b rv=%0b exp 1 0", b_empty, b_rd_valid); else passes++;
      $display("test_fwft done");
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_full_rw();
      test_empty_rw();
      test_flush();
      test_fwft();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
